wash_program_sequencer: RTL and testbench

Program sequencer and timebase for the washing-machine controller FSM. It latches a wash program, times each motor phase (soap wash, rinse, spin), and issues the registered `cycle_timeout` / `spin_timeout` strobes the FSM consumes. An optional valve watchdog flags a stuck fill or drain. It sits beside the FSM: FSM outputs in, timeout strobes out.

---
 rtl/wash_pkg.sv | 51 +++++
 rtl/wash_tick_gen.sv | 37 +++
 rtl/wash_program_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_wash_program_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the wash program sequencer.
// Holds the state encoding, program codes, per-program durations and fault codes.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_MOTOR = 3'd1,
    ST_RUN_WASH   = 3'd2,
    ST_RUN_SPIN   = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PROG_QUICK      = 2'd0,
    PROG_NORMAL     = 2'd1,
    PROG_HEAVY      = 2'd2,
    PROG_ALT_NORMAL = 2'd3
  } prog_e;

  localparam int unsigned QUICK_WASH_TICKS  = 20;
  localparam int unsigned QUICK_SPIN_TICKS  = 10;
  localparam int unsigned NORMAL_WASH_TICKS = 40;
  localparam int unsigned NORMAL_SPIN_TICKS = 20;
  localparam int unsigned HEAVY_WASH_TICKS  = 60;
  localparam int unsigned HEAVY_SPIN_TICKS  = 30;

  // Phases 0 and 1 are soap wash and rinse; phase 2 is the spin.
  localparam logic [1:0] PH_SPIN = 2'd2;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_FILL  = 2'b01;
  localparam logic [1:0] FC_DRAIN = 2'b10;

  // The unused program code 3 behaves as the normal program.
  function automatic int unsigned wash_ticks(input prog_e p);
    case (p)
      PROG_QUICK: return QUICK_WASH_TICKS;
      PROG_HEAVY: return HEAVY_WASH_TICKS;
      default:    return NORMAL_WASH_TICKS;
    endcase
  endfunction

  function automatic int unsigned spin_ticks(input prog_e p);
    case (p)
      PROG_QUICK: return QUICK_SPIN_TICKS;
      PROG_HEAVY: return HEAVY_SPIN_TICKS;
      default:    return NORMAL_SPIN_TICKS;
    endcase
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Timebase prescaler: one-clk tick every CLK_DIV enabled cycles, clear restarts the period.
// Tick is decoded from the divider register; disabling en freezes the divider in place.
module wash_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = en && !clr && (div_q == DIV_LAST);

endmodule

// File: rtl/wash_program_sequencer.sv
// Wash program sequencer: phase timer, registered timeout strobes, optional valve watchdog (WASH_WATCHDOG_EN).
// Strobe lands T*CLK_DIV cycles after the sampled motor rising edge; motor_on low pauses the timer cycle for cycle.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int CLK_DIV     = 100,
  parameter int CNT_W       = 12,
  parameter int VALVE_LIMIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog_sel,
  input  logic             prog_load,
  input  logic             abort,
  input  logic             motor_on,
  input  logic             fill_valve_on,
  input  logic             drain_valve_on,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] VLIM    = CNT_W'(VALVE_LIMIT);

  state_e           state_q, state_d;
  prog_e            prog_q, prog_d;
  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             motor_prev_q;
  logic             cyc_to_q, cyc_to_d;
  logic             spin_to_q, spin_to_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [1:0]       fcode_q, fcode_d;

  logic motor_rise;
  logic running;
  logic tick;
  logic presc_clr;
  logic presc_en;
  logic fill_trip;
  logic drain_trip;

  assign motor_rise = motor_on && !motor_prev_q;
  assign running    = (state_q == ST_RUN_WASH) || (state_q == ST_RUN_SPIN);

  // The timebase free-runs while waiting so the watchdog has ticks; a phase start realigns it.
  assign presc_clr = (state_q == ST_IDLE) || (state_q == ST_FAULT) ||
                     ((state_q == ST_WAIT_MOTOR) && motor_rise);
  assign presc_en  = (state_q == ST_WAIT_MOTOR) || (running && motor_on);

  wash_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

`ifdef WASH_WATCHDOG_EN
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    fill_cnt_d  = '0;
    drain_cnt_d = '0;
    if (state_q == ST_WAIT_MOTOR) begin
      if (fill_valve_on) begin
        fill_cnt_d = tick ? fill_cnt_q + CNT_ONE : fill_cnt_q;
      end
      if (drain_valve_on) begin
        drain_cnt_d = tick ? drain_cnt_q + CNT_ONE : drain_cnt_q;
      end
    end
  end

  // Trip on the tick that would push the open-time past the limit.
  assign fill_trip  = (state_q == ST_WAIT_MOTOR) && fill_valve_on && tick && (fill_cnt_q >= VLIM);
  assign drain_trip = (state_q == ST_WAIT_MOTOR) && drain_valve_on && tick && (drain_cnt_q >= VLIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end
`else
  logic unused_wd;
  assign unused_wd  = ^{fill_valve_on, drain_valve_on, VLIM};
  assign fill_trip  = 1'b0;
  assign drain_trip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    cyc_to_d  = 1'b0;
    spin_to_d = 1'b0;
    fault_d   = fault_q;
    fcode_d   = fcode_q;

    case (state_q)
      ST_IDLE: begin
        if (prog_load) begin
          prog_d  = prog_e'(prog_sel);
          ph_d    = 2'd0;
          state_d = ST_WAIT_MOTOR;
        end
      end

      ST_WAIT_MOTOR: begin
        if (fill_trip || drain_trip) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          fcode_d = fill_trip ? FC_FILL : FC_DRAIN;
        end else if (motor_rise) begin
          if (ph_q == PH_SPIN) begin
            cnt_d   = CNT_W'(spin_ticks(prog_q));
            state_d = ST_RUN_SPIN;
          end else begin
            cnt_d   = CNT_W'(wash_ticks(prog_q));
            state_d = ST_RUN_WASH;
          end
        end
      end

      ST_RUN_WASH: begin
        if (tick) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d    = '0;
            cyc_to_d = 1'b1;
            ph_d     = ph_q + 2'd1;
            state_d  = ST_WAIT_MOTOR;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_RUN_SPIN: begin
        if (tick) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d     = '0;
            spin_to_d = 1'b1;
            ph_d      = 2'd0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats everything, including a terminal count in the same cycle.
    if (abort) begin
      state_d   = ST_IDLE;
      ph_d      = 2'd0;
      cnt_d     = '0;
      cyc_to_d  = 1'b0;
      spin_to_d = 1'b0;
      fault_d   = 1'b0;
      fcode_d   = FC_NONE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prog_q       <= PROG_QUICK;
      ph_q         <= 2'd0;
      cnt_q        <= '0;
      motor_prev_q <= 1'b0;
      cyc_to_q     <= 1'b0;
      spin_to_q    <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fcode_q      <= FC_NONE;
    end else begin
      state_q      <= state_d;
      prog_q       <= prog_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      motor_prev_q <= motor_on;
      cyc_to_q     <= cyc_to_d;
      spin_to_q    <= spin_to_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fcode_q      <= fcode_d;
    end
  end

  assign cycle_timeout = cyc_to_q;
  assign spin_timeout  = spin_to_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign fault_code    = fcode_q;
  assign remaining     = cnt_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer at CLK_DIV=4, VALVE_LIMIT=5.
// Inputs change and outputs are sampled on the falling edge; edge_cnt numbers rising edges.
module tb_wash_program_sequencer;

  localparam int CLK_DIV     = 4;
  localparam int CNT_W       = 12;
  localparam int VALVE_LIMIT = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       prog_sel = 2'd0;
  logic             prog_load = 1'b0;
  logic             abort = 1'b0;
  logic             motor_on = 1'b0;
  logic             fill_valve_on = 1'b0;
  logic             drain_valve_on = 1'b0;
  logic             cycle_timeout;
  logic             spin_timeout;
  logic             busy;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] remaining;

  int edge_cnt  = 0;
  int n_chk     = 0;
  int n_bad     = 0;
  int seen_strb = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  wash_program_sequencer #(
    .CLK_DIV     (CLK_DIV),
    .CNT_W       (CNT_W),
    .VALVE_LIMIT (VALVE_LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .prog_sel       (prog_sel),
    .prog_load      (prog_load),
    .abort          (abort),
    .motor_on       (motor_on),
    .fill_valve_on  (fill_valve_on),
    .drain_valve_on (drain_valve_on),
    .cycle_timeout  (cycle_timeout),
    .spin_timeout   (spin_timeout),
    .busy           (busy),
    .fault          (fault),
    .fault_code     (fault_code),
    .remaining      (remaining)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cycle_timeout || spin_timeout) seen_strb++;
    end
  endtask

  task automatic load_prog(input logic [1:0] p);
    prog_sel  = p;
    prog_load = 1'b1;
    @(negedge clk);
    prog_load = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // kind: 1 cycle_timeout, 2 spin_timeout, 0 nothing within budget.
  task automatic wait_any(input int budget, output int at_edge, output int kind);
    kind    = 0;
    at_edge = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cycle_timeout || spin_timeout) begin
        at_edge = edge_cnt;
        kind    = spin_timeout ? 2 : 1;
        break;
      end
    end
  endtask

  task automatic run_phase(input string tag, input int exp_kind, input int exp_lat);
    int e;
    int t;
    int k;
    motor_on = 1'b0;
    @(negedge clk);
    motor_on = 1'b1;
    e = edge_cnt + 1;
    wait_any(400, t, k);
    chk_eq({tag, "_kind"}, k, exp_kind);
    chk_eq({tag, "_lat"}, t - e, exp_lat);
    @(negedge clk);
    chk_eq({tag, "_single"}, int'(cycle_timeout | spin_timeout), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got edge %0d want finish", edge_cnt);
    $fatal(1, "bench timed out");
  end

  initial begin
    int e;
    int t;
    int k;

    // Reset state
    step_n(2);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_cyc", int'(cycle_timeout), 0);
    chk_eq("rst_spin", int'(spin_timeout), 0);
    chk_eq("rst_fault", int'(fault), 0);
    chk_eq("rst_fcode", int'(fault_code), 0);
    chk_eq("rst_rem", int'(remaining), 0);
    reset = 1'b1;
    step_n(2);

    // Quick wash phase: 20 ticks * 4 = 80 cycles
    load_prog(2'd0);
    chk_eq("q_busy", int'(busy), 1);
    motor_on = 1'b1;
    e = edge_cnt + 1;
    step_n(1);
    chk_eq("q_rem_load", int'(remaining), 20);
    step_n(4);
    chk_eq("q_rem_tick1", int'(remaining), 19);
    wait_any(400, t, k);
    chk_eq("q_kind", k, 1);
    chk_eq("q_lat", t - e, 80);
    chk_eq("q_rem_end", int'(remaining), 0);
    step_n(1);
    chk_eq("q_single", int'(cycle_timeout), 0);
    chk_eq("q_busy_wait", int'(busy), 1);
    motor_on = 1'b0;
    do_abort();
    chk_eq("q_abort_idle", int'(busy), 0);

    // Full normal program: two washes then spin
    load_prog(2'd1);
    run_phase("n_w0", 1, 160);
    run_phase("n_w1", 1, 160);
    run_phase("n_sp", 2, 80);
    chk_eq("n_busy_after", int'(busy), 0);
    motor_on = 1'b0;
    step_n(1);

    // Quick wash with a 10-cycle pause
    load_prog(2'd0);
    motor_on = 1'b1;
    e = edge_cnt + 1;
    seen_strb = 0;
    step_n(31);
    motor_on = 1'b0;
    step_n(10);
    chk_eq("p_rem_frozen", int'(remaining), 13);
    motor_on = 1'b1;
    wait_any(400, t, k);
    chk_eq("p_early", seen_strb, 0);
    chk_eq("p_lat", t - e, 90);
    motor_on = 1'b0;
    do_abort();

    // prog_load during RUN_WASH must not change the running program
    load_prog(2'd0);
    motor_on = 1'b1;
    e = edge_cnt + 1;
    step_n(20);
    prog_sel  = 2'd2;
    prog_load = 1'b1;
    step_n(1);
    prog_load = 1'b0;
    wait_any(400, t, k);
    chk_eq("pl_lat", t - e, 80);
    motor_on = 1'b0;
    do_abort();

    // Program code 3 runs as normal; abort on the terminal-count edge
    load_prog(2'd3);
    motor_on = 1'b1;
    e = edge_cnt + 1;
    seen_strb = 0;
    step_n(160);
    chk_eq("ab_rem_last", int'(remaining), 1);
    abort = 1'b1;
    step_n(1);
    abort = 1'b0;
    chk_eq("ab_no_strobe", int'(cycle_timeout), 0);
    chk_eq("ab_idle", int'(busy), 0);
    chk_eq("ab_rem", int'(remaining), 0);
    step_n(5);
    chk_eq("ab_strobes", seen_strb, 0);
    motor_on = 1'b0;
    step_n(1);

    // Valve watchdog: fill, then drain, stuck open for 30 cycles
    load_prog(2'd0);
    fill_valve_on = 1'b1;
    seen_strb = 0;
    step_n(30);
`ifdef WASH_WATCHDOG_EN
    chk_eq("wf_fault", int'(fault), 1);
    chk_eq("wf_code", int'(fault_code), 1);
`else
    chk_eq("wf_fault", int'(fault), 0);
    chk_eq("wf_code", int'(fault_code), 0);
`endif
    chk_eq("wf_busy", int'(busy), 1);
    chk_eq("wf_strobes", seen_strb, 0);
    fill_valve_on = 1'b0;
    do_abort();
    chk_eq("wf_clr_fault", int'(fault), 0);
    chk_eq("wf_clr_code", int'(fault_code), 0);
    chk_eq("wf_clr_busy", int'(busy), 0);

    load_prog(2'd0);
    drain_valve_on = 1'b1;
    step_n(30);
`ifdef WASH_WATCHDOG_EN
    chk_eq("wd_fault", int'(fault), 1);
    chk_eq("wd_code", int'(fault_code), 2);
`else
    chk_eq("wd_fault", int'(fault), 0);
    chk_eq("wd_code", int'(fault_code), 0);
`endif
    drain_valve_on = 1'b0;
    do_abort();
    chk_eq("wd_clr_fault", int'(fault), 0);

    // Reset pulled low mid-spin
    load_prog(2'd0);
    run_phase("r_w0", 1, 80);
    run_phase("r_w1", 1, 80);
    motor_on = 1'b0;
    step_n(1);
    motor_on = 1'b1;
    step_n(21);
    chk_eq("r_rem_spin", int'(remaining), 5);
    chk_eq("r_busy_spin", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk_eq("r_async_busy", int'(busy), 0);
    chk_eq("r_async_rem", int'(remaining), 0);
    chk_eq("r_async_spin", int'(spin_timeout), 0);
    chk_eq("r_async_cyc", int'(cycle_timeout), 0);
    @(negedge clk);
    reset = 1'b1;
    motor_on = 1'b0;
    step_n(1);
    motor_on = 1'b1;
    seen_strb = 0;
    step_n(100);
    chk_eq("r_noload_strobes", seen_strb, 0);
    chk_eq("r_noload_busy", int'(busy), 0);
    chk_eq("r_noload_rem", int'(remaining), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
